// File: rtl/execute_stage.sv
// EX stage of the in-order RV32I pipeline: operand forwarding, ALU, branch/jump
// resolution and the EX/MEM register with a single-cycle redirect pulse.
module execute_stage #(
   parameter int WIDTH = 32,
   parameter int CTLW  = 23
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             EXclear,
   input  logic             EXstall,
   input  logic [WIDTH-1:0] EXDalua,
   input  logic [WIDTH-1:0] EXDalub,
   input  logic             EXDbreg,
   input  logic [WIDTH-1:0] EXDreg2data,
   input  logic [1:0]       EXDregfwda,
   input  logic [1:0]       EXDregfwdb,
   input  logic [3:0]       EXDalucont,
   input  logic [1:0]       EXDbranchcntl,
   input  logic [2:0]       EXDbrfunct3,
   input  logic [1:0]       EXDpcsource,
   input  logic [WIDTH-1:0] EXDbranchimm,
   input  logic [WIDTH-1:0] EXDpc,
   input  logic [4:0]       EXDrd,
   input  logic [CTLW-1:0]  EXDctl,
   input  logic [WIDTH-1:0] MWwbdata,
   output logic [WIDTH-1:0] EXMresult,
   output logic [WIDTH-1:0] EXMstoredata,
   output logic [4:0]       EXMrd,
   output logic [CTLW-1:0]  EXMctl,
   output logic             EXredirect,
   output logic [WIDTH-1:0] EXtarget
);

   logic [WIDTH-1:0] result_q, result_d;
   logic [WIDTH-1:0] storedata_q, storedata_d;
   logic [4:0]       rd_q, rd_d;
   logic [CTLW-1:0]  ctl_q, ctl_d;
   logic             redirect_q, redirect_d;
   logic [WIDTH-1:0] target_q, target_d;

   logic [WIDTH-1:0] op_a, op_b, fwd_b, store_val, alu_out, br_target;
   logic             taken, do_redirect;

   always_comb begin
      op_a = EXDalua;
      if (EXDregfwda == 2'b01)      op_a = result_q;
      else if (EXDregfwda == 2'b10) op_a = MWwbdata;

      fwd_b = EXDalub;
      if (EXDregfwdb == 2'b01)      fwd_b = result_q;
      else if (EXDregfwdb == 2'b10) fwd_b = MWwbdata;
      op_b = EXDbreg ? fwd_b : EXDalub;

      store_val = EXDreg2data;
      if (EXDregfwdb == 2'b01)      store_val = result_q;
      else if (EXDregfwdb == 2'b10) store_val = MWwbdata;
   end

   always_comb begin
      alu_out = '0;
      case (EXDalucont)
         4'd0:    alu_out = op_a + op_b;
         4'd1:    alu_out = op_a - op_b;
         4'd2:    alu_out = op_a << op_b[4:0];
         4'd3:    alu_out = {{(WIDTH-1){1'b0}}, $signed(op_a) < $signed(op_b)};
         4'd4:    alu_out = {{(WIDTH-1){1'b0}}, op_a < op_b};
         4'd5:    alu_out = op_a ^ op_b;
         4'd6:    alu_out = op_a >> op_b[4:0];
         4'd7:    alu_out = $signed(op_a) >>> op_b[4:0];
         4'd8:    alu_out = op_a | op_b;
         4'd9:    alu_out = op_a & op_b;
         4'd10:   alu_out = op_b;
         default: alu_out = '0;
      endcase
   end

   always_comb begin
      taken = 1'b0;
      if (EXDbranchcntl == 2'b01) begin
         case (EXDbrfunct3)
            3'b000:  taken = (op_a == op_b);
            3'b001:  taken = (op_a != op_b);
            3'b100:  taken = ($signed(op_a) < $signed(op_b));
            3'b101:  taken = ($signed(op_a) >= $signed(op_b));
            3'b110:  taken = (op_a < op_b);
            3'b111:  taken = (op_a >= op_b);
            default: taken = 1'b0;
         endcase
      end
      do_redirect = taken || (EXDbranchcntl == 2'b10);

      case (EXDpcsource)
         2'b00:   br_target = EXDpc + WIDTH'(4);
         2'b10:   br_target = (op_a + EXDbranchimm) & ~WIDTH'(1);
         default: br_target = EXDpc + EXDbranchimm;
      endcase
   end

   // Priority: clear, then stall (hold, drop redirect), then squash of the
   // wrong-path instruction that follows a redirect.
   always_comb begin
      result_d    = result_q;
      storedata_d = storedata_q;
      rd_d        = rd_q;
      ctl_d       = ctl_q;
      target_d    = target_q;
      redirect_d  = 1'b0;
      if (EXclear || (!EXstall && redirect_q)) begin
         result_d    = '0;
         storedata_d = '0;
         rd_d        = '0;
         ctl_d       = '0;
         target_d    = '0;
      end else if (!EXstall) begin
         result_d    = (EXDbranchcntl == 2'b10) ? EXDpc + WIDTH'(4) : alu_out;
         storedata_d = store_val;
         rd_d        = EXDrd;
         ctl_d       = EXDctl;
         redirect_d  = do_redirect;
         target_d    = do_redirect ? br_target : '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         result_q    <= '0;
         storedata_q <= '0;
         rd_q        <= '0;
         ctl_q       <= '0;
         redirect_q  <= 1'b0;
         target_q    <= '0;
      end else begin
         result_q    <= result_d;
         storedata_q <= storedata_d;
         rd_q        <= rd_d;
         ctl_q       <= ctl_d;
         redirect_q  <= redirect_d;
         target_q    <= target_d;
      end
   end

   assign EXMresult    = result_q;
   assign EXMstoredata = storedata_q;
   assign EXMrd        = rd_q;
   assign EXMctl       = ctl_q;
   assign EXredirect   = redirect_q;
   assign EXtarget     = target_q;

endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: directed scenarios plus randomized traffic, all
// checked cycle by cycle against a behavioural model of the EX stage.
module tb_execute_stage;

   localparam int WIDTH = 32;
   localparam int CTLW  = 23;

   logic             clk = 1'b0;
   logic             reset_n, EXclear, EXstall, EXDbreg;
   logic [WIDTH-1:0] EXDalua, EXDalub, EXDreg2data, EXDbranchimm, EXDpc, MWwbdata;
   logic [1:0]       EXDregfwda, EXDregfwdb, EXDbranchcntl, EXDpcsource;
   logic [3:0]       EXDalucont;
   logic [2:0]       EXDbrfunct3;
   logic [4:0]       EXDrd;
   logic [CTLW-1:0]  EXDctl;
   logic [WIDTH-1:0] EXMresult, EXMstoredata, EXtarget;
   logic [4:0]       EXMrd;
   logic [CTLW-1:0]  EXMctl;
   logic             EXredirect;

   int total = 0;
   int bad   = 0;

   // model of the EX/MEM register contents
   logic [WIDTH-1:0] m_result, m_store, m_target;
   logic [4:0]       m_rd;
   logic [CTLW-1:0]  m_ctl;
   logic             m_redir;

   always #5 clk = ~clk;

   execute_stage #(.WIDTH(WIDTH), .CTLW(CTLW)) dut (
      .clk(clk), .reset_n(reset_n), .EXclear(EXclear), .EXstall(EXstall),
      .EXDalua(EXDalua), .EXDalub(EXDalub), .EXDbreg(EXDbreg),
      .EXDreg2data(EXDreg2data), .EXDregfwda(EXDregfwda), .EXDregfwdb(EXDregfwdb),
      .EXDalucont(EXDalucont), .EXDbranchcntl(EXDbranchcntl),
      .EXDbrfunct3(EXDbrfunct3), .EXDpcsource(EXDpcsource),
      .EXDbranchimm(EXDbranchimm), .EXDpc(EXDpc), .EXDrd(EXDrd), .EXDctl(EXDctl),
      .MWwbdata(MWwbdata), .EXMresult(EXMresult), .EXMstoredata(EXMstoredata),
      .EXMrd(EXMrd), .EXMctl(EXMctl), .EXredirect(EXredirect), .EXtarget(EXtarget)
   );

   task automatic chk(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [WIDTH-1:0] ref_alu(input int op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      int sh;
      longint sa, sb;
      sh = int'(b % 32);
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         0:  return a + b;
         1:  return a - b;
         2:  return a << sh;
         3:  return (sa < sb) ? 1 : 0;
         4:  return (a < b) ? 1 : 0;
         5:  return a ^ b;
         6:  return a >> sh;
         7:  return WIDTH'(sa >>> sh);
         8:  return a | b;
         9:  return a & b;
         10: return b;
         default: return 0;
      endcase
   endfunction

   function automatic logic [WIDTH-1:0] pick(input logic [1:0] sel, input logic [WIDTH-1:0] raw);
      if (sel == 2'b01) return m_result;
      if (sel == 2'b10) return MWwbdata;
      return raw;
   endfunction

   function automatic logic ref_taken(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      longint sa, sb;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (EXDbranchcntl != 2'b01) return 1'b0;
      case (EXDbrfunct3)
         3'd0: return a == b;
         3'd1: return a != b;
         3'd4: return sa < sb;
         3'd5: return sa >= sb;
         3'd6: return a < b;
         3'd7: return a >= b;
         default: return 1'b0;
      endcase
   endfunction

   // advance the model by one edge using current inputs, then compare
   task automatic step();
      logic [WIDTH-1:0] a, b;
      logic             jump, tk;
      if (!reset_n || EXclear || (!EXstall && m_redir)) begin
         m_result = '0; m_store = '0; m_rd = '0; m_ctl = '0; m_redir = 1'b0; m_target = '0;
      end else if (EXstall) begin
         m_redir = 1'b0;
      end else begin
         a    = pick(EXDregfwda, EXDalua);
         b    = EXDbreg ? pick(EXDregfwdb, EXDalub) : EXDalub;
         jump = (EXDbranchcntl == 2'b10);
         tk   = ref_taken(a, b);
         m_store  = pick(EXDregfwdb, EXDreg2data);
         m_result = jump ? EXDpc + 4 : ref_alu(int'(EXDalucont), a, b);
         m_rd     = EXDrd;
         m_ctl    = EXDctl;
         m_redir  = tk || jump;
         if (EXDpcsource == 2'b00)      m_target = EXDpc + 4;
         else if (EXDpcsource == 2'b10) m_target = (a + EXDbranchimm) & ~32'd1;
         else                           m_target = EXDpc + EXDbranchimm;
      end
      @(posedge clk);
      #1;
      chk("result", EXMresult, m_result);
      chk("storedata", EXMstoredata, m_store);
      chk("rd", WIDTH'(EXMrd), WIDTH'(m_rd));
      chk("ctl", WIDTH'(EXMctl), WIDTH'(m_ctl));
      chk("redirect", WIDTH'(EXredirect), WIDTH'(m_redir));
      if (m_redir) chk("target", EXtarget, m_target);
   endtask

   task automatic idle();
      reset_n = 1'b1; EXclear = 1'b0; EXstall = 1'b0; EXDbreg = 1'b1;
      EXDalua = '0; EXDalub = '0; EXDreg2data = '0; EXDbranchimm = '0; EXDpc = '0;
      MWwbdata = '0; EXDregfwda = 2'b00; EXDregfwdb = 2'b00; EXDbranchcntl = 2'b00;
      EXDpcsource = 2'b00; EXDalucont = 4'd0; EXDbrfunct3 = 3'd0; EXDrd = 5'd1;
      EXDctl = 23'h400001;
   endtask

   function automatic logic [WIDTH-1:0] rnd_val();
      case ($urandom_range(3))
         0:       return WIDTH'($urandom_range(7));
         1:       return 32'hFFFF_FFFF - WIDTH'($urandom_range(3));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      m_result = '0; m_store = '0; m_rd = '0; m_ctl = '0; m_redir = 1'b0; m_target = '0;
      idle();
      reset_n = 1'b0;
      step();
      step();
      chk("reset_result", EXMresult, 0);
      chk("reset_redirect", WIDTH'(EXredirect), 0);

      // ADD 5 + 7
      idle(); EXDalua = 5; EXDalub = 7; EXDbreg = 1'b0;
      step();
      chk("add", EXMresult, 12);
      chk("add_noredir", WIDTH'(EXredirect), 0);

      // forward previous result into A
      EXDregfwda = 2'b01; EXDalua = 99; EXDalub = 3;
      step();
      chk("fwd_a", EXMresult, 15);

      // forward MEM/WB data into B
      EXDregfwda = 2'b00; EXDalua = 1; EXDregfwdb = 2'b10; EXDbreg = 1'b1; MWwbdata = 100;
      step();
      chk("fwd_b", EXMresult, 101);
      chk("fwd_store", EXMstoredata, 100);

      // BLT -1 < 1, then a squashed follower
      idle(); EXDbranchcntl = 2'b01; EXDbrfunct3 = 3'b100; EXDpcsource = 2'b01;
      EXDpc = 32'h100; EXDbranchimm = 32'hFFFF_FFF8; EXDalua = 32'hFFFF_FFFF; EXDalub = 1;
      step();
      chk("blt_redir", WIDTH'(EXredirect), 1);
      chk("blt_target", EXtarget, 32'h0F8);
      idle(); EXDalua = 4; EXDalub = 4; EXDrd = 5'd9;
      step();
      chk("squash_ctl", WIDTH'(EXMctl), 0);
      chk("squash_redir", WIDTH'(EXredirect), 0);

      // JALR
      idle(); EXDbranchcntl = 2'b10; EXDpcsource = 2'b10; EXDalua = 32'h2003;
      EXDbranchimm = 4; EXDpc = 32'h40;
      step();
      chk("jalr_target", EXtarget, 32'h2006);
      chk("jalr_link", EXMresult, 32'h44);
      idle();
      step();

      // taken BEQ held by a 3-cycle stall, then released
      idle(); EXDalua = 8; EXDalub = 8; step();
      EXDbranchcntl = 2'b01; EXDbrfunct3 = 3'b000; EXDpcsource = 2'b01;
      EXDpc = 32'h200; EXDbranchimm = 32'h20; EXDstall_loop: for (int i = 0; i < 3; i++) begin
         EXstall = 1'b1;
         step();
         chk("stall_hold", EXMresult, 16);
         chk("stall_noredir", WIDTH'(EXredirect), 0);
      end
      EXstall = 1'b0;
      step();
      chk("release_redir", WIDTH'(EXredirect), 1);
      chk("release_target", EXtarget, 32'h220);
      step();
      chk("release_once", WIDTH'(EXredirect), 0);

      // reset in the middle of a redirect
      step();
      chk("pre_reset_redir", WIDTH'(EXredirect), 1);
      reset_n = 1'b0;
      step();
      chk("mid_reset_redir", WIDTH'(EXredirect), 0);
      chk("mid_reset_ctl", WIDTH'(EXMctl), 0);

      // clear on a taken jump
      idle(); EXDbranchcntl = 2'b10; EXclear = 1'b1;
      step();
      chk("clear_ctl", WIDTH'(EXMctl), 0);
      chk("clear_redir", WIDTH'(EXredirect), 0);

      // randomized traffic
      for (int n = 0; n < 600; n++) begin
         reset_n       = ($urandom_range(60) != 0);
         EXclear       = ($urandom_range(12) == 0);
         EXstall       = !m_redir && ($urandom_range(5) == 0);
         EXDbreg       = 1'($urandom);
         EXDalua       = rnd_val();
         EXDalub       = rnd_val();
         EXDreg2data   = $urandom;
         MWwbdata      = rnd_val();
         EXDregfwda    = 2'($urandom);
         EXDregfwdb    = 2'($urandom);
         EXDalucont    = 4'($urandom);
         EXDbranchcntl = ($urandom_range(2) == 0) ? 2'($urandom) : 2'b00;
         EXDbrfunct3   = 3'($urandom);
         EXDpcsource   = 2'($urandom);
         EXDbranchimm  = $urandom;
         EXDpc         = $urandom & ~32'd3;
         EXDrd         = 5'($urandom);
         EXDctl        = 23'($urandom);
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
